// File: rtl/instr_fetch.sv
// instr_fetch: single-byte instruction fetch FSM with PC sequencing; INSTR_FETCH_RAS_EN enables the call/return address stack.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ir_load,
  input  logic              pc_load,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              call_en,
  input  logic              ret_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_data,
  output logic [7:0]        IR,
  output logic              ir_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] pc_inc;
  assign pc_inc = pc + ADDR_W'(1);
  always_comb begin
    nxt = IDLE;
    nxt = state == IDLE ? (ir_load ? REQ : IDLE) :
          state == REQ  ? (mem_ready ? DONE : REQ) : IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      IR <= '0;
      mem_addr <= RESET_PC;
    end else begin
      state <= nxt;
      if (state == IDLE && ir_load) mem_addr <= pc;
      if (state == REQ && mem_ready) IR <= mem_data;
    end
  end
  assign mem_req = state == REQ;
  assign busy = state == REQ;
  assign ir_valid = state == DONE;
`ifdef INSTR_FETCH_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PW:0] cnt;
  logic [PW-1:0] top;
  logic full, empty;
  assign top = cnt[PW-1:0] - PW'(1);
  // depth is a power of two, so the count MSB alone marks a full stack
  assign full = cnt[PW];
  assign empty = cnt == '0;
  always_ff @(posedge clock)
    if (!ret_en && call_en && !full) ras[cnt[PW-1:0]] <= pc_inc;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      cnt <= '0;
      stack_err <= 1'b0;
    end else if (ret_en) begin
      if (empty) stack_err <= 1'b1;
      else begin
        pc <= ras[top];
        cnt <= cnt - (PW+1)'(1);
      end
    end else if (call_en) begin
      pc <= jump_addr;
      if (full) stack_err <= 1'b1;
      else cnt <= cnt + (PW+1)'(1);
    end else if (jump_en) pc <= jump_addr;
    else if (pc_load) pc <= pc_inc;
  end
`else
  logic unused;
  assign unused = ret_en;
  assign stack_err = 1'b0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else if (call_en || jump_en) pc <= jump_addr;
    else if (pc_load) pc <= pc_inc;
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch; expectations follow INSTR_FETCH_RAS_EN.
module tb_instr_fetch;
  logic clock = 0, reset = 1;
  logic ir_load = 0, pc_load = 0, jump_en = 0, call_en = 0, ret_en = 0, mem_ready = 0;
  logic [7:0] jump_addr = 0, mem_data = 0;
  logic mem_req, ir_valid, busy, stack_err;
  logic [7:0] mem_addr, IR, pc;
  int checks = 0, errors = 0;
  typedef struct { logic [7:0] addr; logic [7:0] data; } exp_t;
  exp_t q[$];

  instr_fetch dut (
    .clock(clock), .reset(reset), .ir_load(ir_load), .pc_load(pc_load),
    .jump_en(jump_en), .jump_addr(jump_addr), .call_en(call_en), .ret_en(ret_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .IR(IR), .ir_valid(ir_valid), .busy(busy), .pc(pc), .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (mem_req && q.size() > 0) chk("mem_addr_in_req", mem_addr, q[0].addr);
      if (ir_valid) begin
        if (q.size() == 0) chk("unexpected_ir_valid", ir_valid, 0);
        else begin
          chk("sb_ir", IR, q[0].data);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic set_pc(input logic [7:0] a);
    jump_en = 1; jump_addr = a;
    tick;
    jump_en = 0;
  endtask

  task automatic call(input logic [7:0] a);
    call_en = 1; jump_addr = a;
    tick;
    call_en = 0;
  endtask

  task automatic ret;
    ret_en = 1;
    tick;
    ret_en = 0;
  endtask

  initial begin
    logic [7:0] rets [4];
    rets = '{8'h51, 8'h41, 8'h31, 8'h21};
    tick;
    chk("rst_pc", pc, 8'h00);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_ir", IR, 8'h00);
    chk("rst_outs", {mem_req, busy, ir_valid, stack_err}, 4'b0000);
    reset = 0;
    // scenario 1: minimum latency fetch
    ir_load = 1; mem_ready = 1; mem_data = 8'h01;
    q.push_back('{8'h00, 8'h01});
    tick;
    ir_load = 0;
    chk("s1_req", {mem_req, busy, ir_valid}, 3'b110);
    chk("s1_addr", mem_addr, 8'h00);
    tick;
    mem_ready = 0;
    chk("s1_valid", {ir_valid, busy}, 2'b10);
    chk("s1_ir", IR, 8'h01);
    tick;
    chk("s1_pulse_end", {ir_valid, busy, mem_req}, 3'b000);
    chk("s1_ir_hold", IR, 8'h01);
    // scenario 2: stalled memory, PC advances, stray ir_load ignored
    ir_load = 1; mem_data = 8'h5A;
    q.push_back('{8'h00, 8'h5A});
    tick;
    ir_load = 0; pc_load = 1;
    tick;
    pc_load = 0;
    for (int i = 0; i < 4; i++) begin
      ir_load = (i == 1);
      chk("s2_stall", {mem_req, busy}, 2'b11);
      chk("s2_addr_held", mem_addr, 8'h00);
      tick;
    end
    ir_load = 0; mem_ready = 1;
    tick;
    mem_ready = 0; ir_load = 1;
    chk("s2_done", {ir_valid, busy}, 2'b10);
    chk("s2_ir", IR, 8'h5A);
    chk("s2_pc", pc, 8'h01);
    tick;
    ir_load = 0;
    tick;
    chk("s2_done_ir_load_ignored", {mem_req, ir_valid}, 2'b00);
    // scenario 3: wrap and jump priority
    set_pc(8'hFF);
    chk("s3_jump", pc, 8'hFF);
    pc_load = 1;
    tick;
    chk("s3_wrap", pc, 8'h00);
    jump_en = 1; jump_addr = 8'h40;
    tick;
    jump_en = 0; pc_load = 0;
    chk("s3_jump_over_inc", pc, 8'h40);
    // scenario 5: return on empty stack
    ret;
    chk("s5_pc", pc, 8'h40);
`ifdef INSTR_FETCH_RAS_EN
    chk("s5_err", stack_err, 1);
`else
    chk("s5_err", stack_err, 0);
`endif
    reset = 1;
    #2;
    chk("rst_clears_err", {stack_err, pc}, 9'h000);
    tick;
    reset = 0;
    // scenario 4: call/return
    set_pc(8'h10);
    call(8'h80);
    chk("s4_call", pc, 8'h80);
    ret;
`ifdef INSTR_FETCH_RAS_EN
    chk("s4_ret", pc, 8'h11);
`else
    chk("s4_ret_ignored", pc, 8'h80);
`endif
    set_pc(8'h20);
    for (int i = 0; i < 5; i++) call(8'h30 + 8'(i) * 8'h10);
    chk("s4_nested_pc", pc, 8'h70);
`ifdef INSTR_FETCH_RAS_EN
    chk("s4_overflow_err", stack_err, 1);
    for (int i = 0; i < 4; i++) begin
      ret;
      chk("s4_pop", pc, rets[i]);
    end
    ret;
    chk("s4_underflow_pc", pc, 8'h21);
`else
    chk("s4_no_err", stack_err, 0);
    ret;
    chk("s4_ret_ignored2", pc, 8'h70);
`endif
    // ret beats call when both are asserted
    reset = 1;
    tick;
    reset = 0;
    call(8'h80);
    ret_en = 1; call_en = 1; jump_addr = 8'h90;
    tick;
    ret_en = 0; call_en = 0;
`ifdef INSTR_FETCH_RAS_EN
    chk("prio_ret_over_call", pc, 8'h01);
`else
    chk("prio_call_as_jump", pc, 8'h90);
`endif
    // scenario 6: reset aborts an outstanding fetch
    ir_load = 1; mem_ready = 0;
    q.push_back('{pc, 8'hEE});
    tick;
    ir_load = 0;
    chk("s6_req", mem_req, 1);
    reset = 1;
    #1;
    chk("s6_async_drop", {mem_req, busy}, 2'b00);
    q.delete();
    mem_ready = 1; mem_data = 8'hEE;
    tick;
    reset = 0;
    tick;
    tick;
    chk("s6_ir_untouched", IR, 8'h00);
    chk("s6_no_valid", ir_valid, 0);
    mem_ready = 0;
    // first fetch accepted on the first edge after reset release
    reset = 1;
    tick;
    reset = 0;
    ir_load = 1; mem_ready = 1; mem_data = 8'h33;
    q.push_back('{8'h00, 8'h33});
    tick;
    ir_load = 0;
    chk("post_rst_req", mem_req, 1);
    tick;
    mem_ready = 0;
    chk("post_rst_ir", IR, 8'h33);
    tick;
    tick;
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
